instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Initiator side of the instruction ROM read port: owns the program counter and drives `RomAddress` into the combinational ROM.
- Captures the returned `Word` together with its PC into a small skid FIFO.
- Presents fetched instructions to decode through a valid/ready handshake.
- Handles control-flow redirects from execute and traps misaligned targets.

Parameters:
- RESET_PC, 0, byte address of the first fetch after reset; must be word-aligned.
- DEPTH, 2, skid FIFO entries; power of two, range 2..8.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- rom_address  output  $bits(RomAddress)  byte address presented to the ROM read port
- rom_data  input  32 (Word)  ROM read data, combinational from rom_address
- redirect_valid  input  1  execute requests a PC change this cycle
- redirect_target  input  $bits(RomAddress)  new byte PC
- out_valid  output  1  out_pc/out_instruction hold a valid fetch
- out_ready  input  1  decode accepts the head entry
- out_pc  output  $bits(RomAddress)  byte address of out_instruction
- out_instruction  output  32 (Word)  fetched instruction
- fault  output  1  sticky misaligned-redirect trap

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low.
  - reset_n low forces pc=RESET_PC, FIFO empty, state=FETCH.
  - While reset_n is low: out_valid=0, fault=0, out_pc=0, out_instruction=0.
  - Reset mid-operation discards all buffered entries immediately.
- rom_address:
  - Always equals the pc register.
  - ROM read is zero-latency: rom_data is sampled in the same cycle.
- Enqueue in FETCH:
  - Condition: state=FETCH, no redirect, and the FIFO is not full or is being popped this cycle.
  - Action: push {pc, rom_data}; pc <= pc+4.
- Wrap-around and full:
  - pc arithmetic is modulo 2^$bits(RomAddress), so the top word wraps to 0.
  - FIFO full with no pop: pc holds and no push occurs.
- Output:
  - Driven from the FIFO head register, so out_valid rises one cycle after the first enqueue (first cycle after reset release).
  - Pop occurs when out_valid && out_ready.
  - out_pc/out_instruction stay stable while out_valid && !out_ready.
  - When out_valid=0, out_pc and out_instruction hold 0.
- Throughput: with out_ready held high, one instruction per cycle with consecutive PCs.
- Redirect, aligned (redirect_target[1:0]==0):
  - FIFO flushes at the clock edge; pc <= redirect_target.
  - out_valid=0 in the following cycle.
  - First target instruction appears on out_* two cycles after the redirect edge.
  - Redirect has priority over a simultaneous push and pop. The popped entry counts as consumed by decode; the pushed entry is dropped.
- Redirect, misaligned (redirect_target[1:0]!=0):
  - state <= FAULT and FIFO flushes.
  - In FAULT: fault=1, out_valid=0, no pushes, pc frozen at its pre-redirect value, further redirects ignored.
  - Only reset_n leaves FAULT.
- State machine: FETCH -> FAULT on misaligned redirect; FAULT -> FETCH only via reset.
- FIFO implementation:
  - Count width is clog2(DEPTH)+1; read and write pointers wrap modulo DEPTH.
  - Simultaneous push and pop when full is legal; the count stays at DEPTH.

Decomposition:
- Shared package (types):
  - FetchEntry struct {RomAddress pc; Word instruction}.
  - INSTRUCTION_BYTES=4 constant.
  - WORD_ADDRESS helper reused for alignment checks.
  - FetchState enum {FETCH, FAULT}.
- One sub-module: fetch_fifo, a synchronous FIFO of FetchEntry parameterised on DEPTH.
  - Ports: push, pop, flush, full, empty, head.
  - Same clock and reset as the parent.
- instruction_fetch contains the pc register, the state machine and the redirect logic.

Test Plan:
- Reset then out_ready=1, ROM preloaded with word i = 0x1000+i -> out_valid from cycle 1; out_pc 0,4,8,... paired with instructions 0x1000,0x1001,0x1002,... with no gaps.
- out_ready=0 for 5 cycles after out_valid rises:
  - out_pc=0 stays stable.
  - pc stops at 4*DEPTH (8 for DEPTH=2).
  - Releasing out_ready resumes the stream 0,4,8,12 with no lost or duplicated entries.
- redirect_valid=1, target=0x40, asserted while out_valid && out_ready:
  - Next cycle out_valid=0.
  - Following cycle out_pc=0x40, out_instruction=word 16.
  - Old sequential entries never appear.
- redirect target=0x42 -> fault=1 next cycle and sticky; out_valid=0; rom_address frozen. Later redirect 0x80 is ignored. reset_n pulse -> fault=0, fetch restarts at RESET_PC.
- RESET_PC = top word of the address space, out_ready=1 -> out_pc sequence is top word then 0x0, wrapping cleanly.
- reset_n asserted asynchronously mid-cycle with the FIFO full -> out_valid drops immediately without waiting for a clock; after release, the first output is RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared types and helpers for the instruction fetch unit.
package instruction_fetch_pkg;

    localparam int ADDRESS_WIDTH     = 16;
    localparam int WORD_WIDTH        = 32;
    localparam int INSTRUCTION_BYTES = 4;

    typedef logic [ADDRESS_WIDTH-1:0] rom_address_t;
    typedef logic [WORD_WIDTH-1:0]    word_t;

    // One buffered fetch: the instruction and the byte address it came from.
    typedef struct packed {
        rom_address_t pc;
        word_t        instruction;
    } fetch_entry_t;

    typedef enum logic {
        FETCH = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    // Word index of a byte address (drops the byte-in-word bits).
    function automatic logic [ADDRESS_WIDTH-3:0] word_address(input rom_address_t address);
        return address[ADDRESS_WIDTH-1:2];
    endfunction

    // An address is aligned when rebuilding it from its word index is lossless.
    function automatic logic is_word_aligned(input rom_address_t address);
        return {word_address(address), 2'b00} == address;
    endfunction

endpackage

// File: rtl/instruction_fetch_fifo.sv
// Small skid FIFO of fetch entries; head is read straight from the entry registers.
module instruction_fetch_fifo
    import instruction_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int PTR_WIDTH   = $clog2(DEPTH);
    localparam int COUNT_WIDTH = PTR_WIDTH + 1;

    fetch_entry_t           entry_reg [DEPTH];
    logic [PTR_WIDTH-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [PTR_WIDTH-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [COUNT_WIDTH-1:0] count_reg, count_next;
    logic                   do_push;
    logic                   do_pop;

    assign full  = (count_reg == COUNT_WIDTH'(DEPTH));
    assign empty = (count_reg == '0);
    assign head  = entry_reg[rd_ptr_reg];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer and occupancy bookkeeping; flush wins over everything else.
    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_WIDTH'(1);
            end
            if (do_push) begin
                wr_ptr_next = wr_ptr_reg + PTR_WIDTH'(1);
            end
            if (do_push && !do_pop) begin
                count_next = count_reg + COUNT_WIDTH'(1);
            end else if (do_pop && !do_push) begin
                count_next = count_reg - COUNT_WIDTH'(1);
            end
        end
    end

    // Control state resets asynchronously so the FIFO empties the moment reset hits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Entry storage needs no reset: contents are only observed behind a non-zero count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (do_push && !flush && (wr_ptr_reg == PTR_WIDTH'(gi))) begin
                    entry_reg[gi] <= push_entry;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/instruction_fetch.sv
// Fetch unit: owns the PC, reads the ROM, buffers fetches and handles redirects.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter rom_address_t RESET_PC = '0,
    parameter int           DEPTH    = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    output rom_address_t rom_address,
    input  word_t        rom_data,
    input  logic         redirect_valid,
    input  rom_address_t redirect_target,
    output logic         out_valid,
    input  logic         out_ready,
    output rom_address_t out_pc,
    output word_t        out_instruction,
    output logic         fault
);

    fetch_state_t state_reg, state_next;
    rom_address_t pc_reg, pc_next;
    logic         fifo_push;
    logic         fifo_pop;
    logic         fifo_flush;
    logic         fifo_full;
    logic         fifo_empty;
    fetch_entry_t fifo_head;
    fetch_entry_t fetch_entry;

    assign rom_address = pc_reg;
    assign fetch_entry = '{pc: pc_reg, instruction: rom_data};

    assign out_valid       = !fifo_empty && (state_reg == FETCH);
    assign fifo_pop        = out_valid && out_ready;
    assign out_pc          = out_valid ? fifo_head.pc : '0;
    assign out_instruction = out_valid ? fifo_head.instruction : '0;

    // Next state, next PC and FIFO control; a redirect pre-empts the sequential fetch.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        fault      = 1'b0;
        case (state_reg)
            FETCH: begin
                if (redirect_valid) begin
                    fifo_flush = 1'b1;
                    if (is_word_aligned(redirect_target)) begin
                        pc_next = redirect_target;
                    end else begin
                        state_next = FAULT;
                    end
                end else if (!fifo_full || fifo_pop) begin
                    fifo_push = 1'b1;
                    pc_next   = pc_reg + rom_address_t'(INSTRUCTION_BYTES);
                end
            end
            FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // State and PC registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= FETCH;
            pc_reg    <= RESET_PC;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    instruction_fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .push_entry(fetch_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: stimulus queues expected fetches, a monitor checks handshakes.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic         out_ready;
    logic         redirect_valid;
    logic         sel_top;
    rom_address_t redirect_target;

    rom_address_t rom_address0, rom_address1, out_pc0, out_pc1;
    word_t        rom_data0, rom_data1, out_instruction0, out_instruction1;
    logic         out_valid0, out_valid1, fault0, fault1;

    int checks_total  = 0;
    int checks_passed = 0;

    fetch_entry_t exp_q[$];
    fetch_entry_t mon_entry;

    // ROM image: word i holds 0x1000 + i.
    function automatic word_t rom_word(input rom_address_t address);
        return 32'h1000 + {18'b0, address[15:2]};
    endfunction

    assign rom_data0 = rom_word(rom_address0);
    assign rom_data1 = rom_word(rom_address1);

    instruction_fetch #(.RESET_PC(16'h0000), .DEPTH(2)) dut0 (
        .clk            (clk),
        .reset_n        (reset_n),
        .rom_address    (rom_address0),
        .rom_data       (rom_data0),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .out_valid      (out_valid0),
        .out_ready      (out_ready && !sel_top),
        .out_pc         (out_pc0),
        .out_instruction(out_instruction0),
        .fault          (fault0)
    );

    instruction_fetch #(.RESET_PC(16'hFFFC), .DEPTH(2)) dut1 (
        .clk            (clk),
        .reset_n        (reset_n),
        .rom_address    (rom_address1),
        .rom_data       (rom_data1),
        .redirect_valid (1'b0),
        .redirect_target(16'h0000),
        .out_valid      (out_valid1),
        .out_ready      (out_ready && sel_top),
        .out_pc         (out_pc1),
        .out_instruction(out_instruction1),
        .fault          (fault1)
    );

    logic         m_valid, m_fault;
    rom_address_t m_pc, m_addr;
    word_t        m_instr;
    assign m_valid = sel_top ? out_valid1 : out_valid0;
    assign m_fault = sel_top ? fault1 : fault0;
    assign m_pc    = sel_top ? out_pc1 : out_pc0;
    assign m_addr  = sel_top ? rom_address1 : rom_address0;
    assign m_instr = sel_top ? out_instruction1 : out_instruction0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic expect_fetch(input rom_address_t address);
        exp_q.push_back('{pc: address, instruction: rom_word(address)});
    endtask

    // Reset pulse; returns one time unit after the release edge (cycle 0 of the new run).
    task automatic do_reset(input logic ready_after, input logic sel_after);
        @(posedge clk);
        #1;
        reset_n        = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check("reset_out_valid", m_valid, 0);
        check("reset_fault", m_fault, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        sel_top   = sel_after;
        reset_n   = 1'b1;
        out_ready = ready_after;
    endtask

    // Monitor: every accepted output must match the head of the expected queue.
    always @(negedge clk) begin
        if (m_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks_total++;
                $display("FAIL unexpected_output: got pc=%h instr=%h, expected no output", m_pc, m_instr);
            end else begin
                mon_entry = exp_q.pop_front();
                $display("txn pc=%h instr=%h (expected pc=%h instr=%h)",
                         m_pc, m_instr, mon_entry.pc, mon_entry.instruction);
                check("txn_pc", m_pc, mon_entry.pc);
                check("txn_instruction", m_instr, mon_entry.instruction);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        reset_n         = 1'b0;
        out_ready       = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        sel_top         = 1'b0;
        #2;
        check("rst_out_valid", out_valid0, 0);
        check("rst_fault", fault0, 0);
        check("rst_out_pc", out_pc0, 0);
        check("rst_out_instruction", out_instruction0, 0);
        check("rst_rom_address", rom_address0, 0);

        // Streaming: eight back-to-back fetches from PC 0.
        do_reset(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) expect_fetch(rom_address_t'(4 * i));
        repeat (9) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("stream_drained", exp_q.size(), 0);

        // Back-pressure: head stays put, PC stops at 4*DEPTH, then resumes cleanly.
        do_reset(1'b0, 1'b0);
        @(negedge clk);
        check("stall_cycle0_valid", m_valid, 0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check("stall_valid", m_valid, 1);
            check("stall_out_pc", m_pc, 0);
            check("stall_out_instruction", m_instr, 32'h1000);
        end
        check("stall_pc_frozen", m_addr, 8);
        for (int i = 0; i < 4; i++) expect_fetch(rom_address_t'(4 * i));
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("stall_drained", exp_q.size(), 0);

        // Aligned redirect to 0x40 while a handshake is in progress.
        do_reset(1'b1, 1'b0);
        expect_fetch(16'h0000);
        expect_fetch(16'h0004);
        expect_fetch(16'h0008);
        expect_fetch(16'h0040);
        expect_fetch(16'h0044);
        expect_fetch(16'h0048);
        repeat (3) @(posedge clk);
        #1;
        redirect_valid  = 1'b1;
        redirect_target = 16'h0040;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        @(negedge clk);
        check("redirect_bubble_valid", m_valid, 0);
        check("redirect_bubble_pc", m_pc, 0);
        check("redirect_rom_address", m_addr, 16'h0040);
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("redirect_drained", exp_q.size(), 0);

        // Misaligned redirect: sticky fault, frozen PC, later redirects ignored.
        do_reset(1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        redirect_valid  = 1'b1;
        redirect_target = 16'h0042;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        @(negedge clk);
        check("fault_set", m_fault, 1);
        check("fault_out_valid", m_valid, 0);
        check("fault_rom_address", m_addr, 8);
        @(posedge clk);
        #1;
        redirect_valid  = 1'b1;
        redirect_target = 16'h0080;
        out_ready       = 1'b1;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        @(negedge clk);
        check("fault_sticky", m_fault, 1);
        check("fault_ignore_redirect", m_addr, 8);
        check("fault_still_invalid", m_valid, 0);
        do_reset(1'b1, 1'b0);
        check("fault_cleared", m_fault, 0);
        expect_fetch(16'h0000);
        expect_fetch(16'h0004);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("fault_restart_drained", exp_q.size(), 0);

        // Wrap-around from the top word of the address space.
        do_reset(1'b1, 1'b1);
        expect_fetch(16'hFFFC);
        expect_fetch(16'h0000);
        expect_fetch(16'h0004);
        expect_fetch(16'h0008);
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("wrap_drained", exp_q.size(), 0);

        // Asynchronous reset mid-cycle with the FIFO full.
        do_reset(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("async_full_valid", m_valid, 1);
        check("async_full_pc", m_addr, 8);
        #2 reset_n = 1'b0;
        #1;
        check("async_valid_drop", m_valid, 0);
        check("async_out_pc", m_pc, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        expect_fetch(16'h0000);
        expect_fetch(16'h0004);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("async_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
